// File: rtl/lcd_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_pkg
// Description : Shared HD44780 write-bus opcodes, DDRAM map and fill value.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_bus_pkg;

    localparam logic [7:0] c_op_clr   = 8'h01;
    localparam logic [7:0] c_op_home  = 8'h02;
    localparam logic [7:0] c_op_entry = 8'h04;
    localparam logic [7:0] c_op_disp  = 8'h08;
    localparam logic [7:0] c_op_shift = 8'h10;
    localparam logic [7:0] c_op_func  = 8'h20;
    localparam logic [7:0] c_op_cgram = 8'h40;
    localparam logic [7:0] c_op_ddram = 8'h80;

    localparam logic [6:0] c_row0_base = 7'h00;
    localparam logic [6:0] c_row1_base = 7'h40;
    localparam logic [6:0] c_row0_end  = 7'h27;
    localparam logic [6:0] c_row1_end  = 7'h67;

    localparam logic [7:0] c_blank = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_ac_step.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ac_step
// Description : Next DDRAM address counter value with two-line wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ac_step
    import lcd_bus_pkg::*;
(
    input  logic [6:0] ac,
    input  logic       dir,
    output logic [6:0] ac_next
);

    always_comb begin
        ac_next = dir ? (ac + 7'd1) : (ac - 7'd1);
        if (dir) begin
            if (ac == c_row0_end)      ac_next = c_row1_base;
            else if (ac == c_row1_end) ac_next = c_row0_base;
        end else begin
            if (ac == c_row1_base)      ac_next = c_row0_end;
            else if (ac == c_row0_base) ac_next = c_row1_end;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_shadow_rx.sv
`default_nettype none
// ============================================================================
// Module      : lcd_shadow_rx
// Description : Decodes LCD write-bus transfers into a 2x16 shadow DDRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_shadow_rx
    import lcd_bus_pkg::*;
#(
    parameter int         ROW_LEN = 16,
    parameter logic [7:0] BLANK   = c_blank
) (
    input  logic       clk_1k,
    input  logic       clr_sw,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       busy,
    output logic       upd,
    output logic       ovr
);

    localparam int c_cells = 2 * ROW_LEN;

    logic [7:0] r_mem [0:c_cells-1];
    logic       r_e_q;
    logic       r_inc;
    logic       r_cgram;
    logic [4:0] r_cnt;
    clr_state_t r_state;

    clr_state_t w_state_nxt;
    logic [6:0] w_ac_nxt;
    logic [6:0] w_ac_step;
    logic       w_inc_nxt;
    logic       w_cgram_nxt;
    logic       w_disp_nxt;
    logic       w_upd_nxt;
    logic       w_wr_en;
    logic [4:0] w_wr_idx;
    logic [7:0] w_wr_val;
    logic       w_xfer;
    logic       w_dir;

    // A write cycle is a falling edge of lcd_e with lcd_rw low.
    assign w_xfer = r_e_q & ~lcd_e & ~lcd_rw;
    assign busy   = (r_state == ST_CLEAR);
    // Data writes follow entry mode; cursor shifts follow R/L.
    assign w_dir  = lcd_rs ? r_inc : lcd_data[2];

    lcd_ac_step u_ac_step (
        .ac      (ac),
        .dir     (w_dir),
        .ac_next (w_ac_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ac_nxt    = ac;
        w_inc_nxt   = r_inc;
        w_cgram_nxt = r_cgram;
        w_disp_nxt  = disp_on;
        w_upd_nxt   = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = {ac[6], ac[3:0]};
        w_wr_val    = lcd_data;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer && !lcd_rs) begin
                    if (|(lcd_data & c_op_ddram)) begin
                        w_ac_nxt    = lcd_data[6:0];
                        w_cgram_nxt = 1'b0;
                    end else if (|(lcd_data & c_op_cgram)) begin
                        w_cgram_nxt = 1'b1;
                    end else if (|(lcd_data & c_op_func)) begin
                        w_ac_nxt = ac;
                    end else if (|(lcd_data & c_op_shift)) begin
                        if (!lcd_data[3]) w_ac_nxt = w_ac_step;
                    end else if (|(lcd_data & c_op_disp)) begin
                        w_disp_nxt = lcd_data[2];
                    end else if (|(lcd_data & c_op_entry)) begin
                        w_inc_nxt = lcd_data[1];
                    end else if (|(lcd_data & c_op_home)) begin
                        w_ac_nxt = c_row0_base;
                    end else if (|(lcd_data & c_op_clr)) begin
                        w_state_nxt = ST_CLEAR;
                    end
                end else if (w_xfer && lcd_rs && !r_cgram) begin
                    w_ac_nxt = w_ac_step;
                    // Only 0x00-0x0F and 0x40-0x4F map onto visible cells.
                    if (ac[5:4] == 2'b00) begin
                        w_wr_en   = 1'b1;
                        w_upd_nxt = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                w_wr_en  = 1'b1;
                w_wr_idx = r_cnt;
                w_wr_val = BLANK;
                if (r_cnt == 5'(c_cells - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_ac_nxt    = c_row0_base;
                    w_inc_nxt   = 1'b1;
                    w_upd_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_1k or posedge clr_sw) begin
        if (clr_sw) begin
            for (int i = 0; i < c_cells; i++) r_mem[i] <= BLANK;
            r_e_q   <= 1'b0;
            r_inc   <= 1'b1;
            r_cgram <= 1'b0;
            r_cnt   <= 5'd0;
            r_state <= ST_IDLE;
            ac      <= 7'd0;
            disp_on <= 1'b0;
            upd     <= 1'b0;
            ovr     <= 1'b0;
            rd_char <= BLANK;
        end else begin
            r_e_q   <= lcd_e;
            r_state <= w_state_nxt;
            r_inc   <= w_inc_nxt;
            r_cgram <= w_cgram_nxt;
            r_cnt   <= busy ? (r_cnt + 5'd1) : 5'd0;
            ac      <= w_ac_nxt;
            disp_on <= w_disp_nxt;
            upd     <= w_upd_nxt;
            if (w_xfer && busy) ovr <= 1'b1;
            if (w_wr_en) r_mem[w_wr_idx] <= w_wr_val;
            rd_char <= r_mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_shadow_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_shadow_rx
// Description : Scoreboard bench for the LCD shadow receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_shadow_rx;

    logic       clk_1k = 1'b0;
    logic       clr_sw = 1'b1;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e  = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       disp_on, busy, upd, ovr;

    lcd_shadow_rx dut (
        .clk_1k   (clk_1k),
        .clr_sw   (clr_sw),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .rd_addr  (rd_addr),
        .rd_char  (rd_char),
        .ac       (ac),
        .disp_on  (disp_on),
        .busy     (busy),
        .upd      (upd),
        .ovr      (ovr)
    );

    always #5 clk_1k = ~clk_1k;

    typedef struct {
        int         sel;
        logic [4:0] addr;
        logic [7:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_go = 1'b0;
    logic cnt_clr = 1'b0;
    int   upd_cnt = 0;
    int   busy_cnt = 0;

    function automatic string sel_name(input int s);
        case (s)
            0: return "rd_char";
            1: return "ac";
            2: return "disp_on";
            3: return "ovr";
            4: return "busy_cycles";
            default: return "upd_pulses";
        endcase
    endfunction

    always @(negedge clk_1k) begin
        if (cnt_clr) begin
            upd_cnt  <= 0;
            busy_cnt <= 0;
        end else begin
            if (upd)  upd_cnt  <= upd_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    // Monitor: pops one expectation each time the driver flags a result.
    always @(negedge clk_1k) begin
        if (mon_go) begin
            if (q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_empty got=none want=entry");
            end else begin
                exp_t it;
                logic [7:0] got;
                it = q.pop_front();
                case (it.sel)
                    0: got = rd_char;
                    1: got = {1'b0, ac};
                    2: got = {7'd0, disp_on};
                    3: got = {7'd0, ovr};
                    4: got = 8'(busy_cnt);
                    default: got = 8'(upd_cnt);
                endcase
                checks = checks + 1;
                if (got !== it.exp) begin
                    errors = errors + 1;
                    $display("FAIL %s addr=%0d got=%h want=%h",
                             sel_name(it.sel), it.addr, got, it.exp);
                end
            end
        end
    end

    task automatic chk(input int sel, input logic [4:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        @(posedge clk_1k); #1;
        q.push_back('{sel, addr, exp});
        mon_go = 1'b1;
        @(posedge clk_1k); #1;
        mon_go = 1'b0;
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        @(posedge clk_1k); #1;
        lcd_e = 1'b0;
        @(posedge clk_1k); #1;
        @(posedge clk_1k); #1;
    endtask

    task automatic clr_counts();
        cnt_clr = 1'b1;
        @(posedge clk_1k); #1;
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_1k);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        clr_sw = 1'b0;
        idle(2);

        // Reset state
        for (int i = 0; i < 32; i++) chk(0, 5'(i), 8'h20);
        chk(2, 0, 8'h00);
        chk(1, 0, 8'h00);
        chk(3, 0, 8'h00);

        // Row 0 writes
        clr_counts();
        xfer(0, 0, 8'h80);
        xfer(1, 0, 8'h57);
        xfer(1, 0, 8'h54);
        chk(0, 0, 8'h57);
        chk(0, 1, 8'h54);
        chk(1, 0, 8'h02);
        chk(5, 0, 8'd2);

        // Row 1 writes
        xfer(0, 0, 8'hC0);
        xfer(1, 0, 8'h31);
        xfer(1, 0, 8'h32);
        xfer(1, 0, 8'h48);
        chk(0, 16, 8'h31);
        chk(0, 17, 8'h32);
        chk(0, 18, 8'h48);
        chk(1, 0, 8'h43);

        // Off-screen write and wraps
        xfer(0, 0, 8'hA7);
        clr_counts();
        xfer(1, 0, 8'h41);
        chk(1, 0, 8'h40);
        chk(5, 0, 8'd0);
        xfer(1, 0, 8'h41);
        chk(0, 16, 8'h41);
        chk(1, 0, 8'h41);
        xfer(0, 0, 8'h04);
        xfer(0, 0, 8'h80);
        xfer(1, 0, 8'h42);
        chk(0, 0, 8'h42);
        chk(1, 0, 8'h67);

        // Clear with a colliding data strobe
        clr_counts();
        xfer(0, 0, 8'h01);
        idle(3);
        xfer(1, 0, 8'h5A);
        idle(40);
        chk(4, 0, 8'd32);
        chk(5, 0, 8'd1);
        chk(3, 0, 8'h01);
        chk(1, 0, 8'h00);
        for (int i = 0; i < 32; i++) chk(0, 5'(i), 8'h20);
        xfer(1, 0, 8'h41);
        chk(1, 0, 8'h01);
        chk(0, 0, 8'h41);

        // Display control, CGRAM discard, read strobes
        xfer(0, 0, 8'h0C);
        chk(2, 0, 8'h01);
        xfer(0, 0, 8'h08);
        chk(2, 0, 8'h00);
        xfer(0, 0, 8'h40);
        xfer(1, 0, 8'h55);
        chk(0, 1, 8'h20);
        chk(1, 0, 8'h01);
        xfer(0, 0, 8'h80);
        xfer(1, 1, 8'h66);
        chk(0, 0, 8'h41);
        chk(1, 0, 8'h00);
        xfer(0, 1, 8'h0C);
        chk(2, 0, 8'h00);

        // Cursor shift wrap, display shift, home
        xfer(0, 0, 8'h10);
        chk(1, 0, 8'h67);
        xfer(0, 0, 8'h14);
        chk(1, 0, 8'h00);
        xfer(0, 0, 8'h1C);
        chk(1, 0, 8'h00);
        xfer(0, 0, 8'h85);
        xfer(0, 0, 8'h02);
        chk(1, 0, 8'h00);

        idle(2);
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
